// File: rtl/av_esram_pkg.sv
// Shared types and default sizes for the Avalon-MM eSRAM host.
package av_esram_pkg;
  localparam int C_ADDR_BITS_DEF = 16;
  localparam int C_WORD_SIZE_DEF = 32;
  localparam int C_LEN_BITS_DEF  = 16;
  localparam int C_TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/av_host_fifo.sv
// Small synchronous FIFO with flush, used as the read-return buffer.
// Depth must be a power of two so the pointers wrap naturally.
module av_host_fifo #(
  parameter int depth = 2,
  parameter int width = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  localparam int AW = $clog2(depth);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointer and occupancy tracking; flush discards everything buffered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/av_esram_host.sv
// Avalon-MM host running single-word sequential block transfers against
// the eSRAM bridge. Only one bus access is ever in flight.
module av_esram_host
  import av_esram_pkg::*;
#(
  parameter int c_ADDR_BITS  = C_ADDR_BITS_DEF,
  parameter int c_WORD_SIZE  = C_WORD_SIZE_DEF,
  parameter int c_LEN_BITS   = C_LEN_BITS_DEF,
  parameter int c_FIFO_DEPTH = 2,
  parameter int c_TIMEOUT    = C_TIMEOUT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [c_ADDR_BITS-1:0]  cmd_addr,
  input  logic [c_LEN_BITS-1:0]   cmd_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [c_WORD_SIZE-1:0]  wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [c_WORD_SIZE-1:0]  rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [c_ADDR_BITS-1:0]  av_address,
  output logic                    av_read,
  output logic                    av_write,
  output logic [c_WORD_SIZE-1:0]  av_writedata,
  input  logic [c_WORD_SIZE-1:0]  av_readdata,
  input  logic                    av_waitrequest
);
  localparam int TW = (c_TIMEOUT > 1) ? $clog2(c_TIMEOUT + 1) : 1;

  state_t                       state;
  state_t                       state_nxt;
  logic [c_LEN_BITS-1:0]        remaining;   // words not yet issued on the bus
  logic [TW-1:0]                wait_cnt;
  logic                         aborted;
  logic                         access;
  logic                         complete;
  logic                         stalled;
  logic                         timeout_hit;
  logic                         cmd_take;
  logic                         wr_take;
  logic                         rd_start;
  logic                         rd_push;
  logic                         rd_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(c_FIFO_DEPTH):0] fifo_count;

  assign access      = av_read | av_write;
  assign complete    = access & ~av_waitrequest;
  assign stalled     = access & av_waitrequest;
  assign timeout_hit = (c_TIMEOUT != 0) && stalled && (wait_cnt == TW'(c_TIMEOUT - 1));

  assign cmd_ready = (state == IDLE) && !reset;
  assign cmd_take  = cmd_valid & cmd_ready;
  assign busy      = (state == WRITE) || (state == READ);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && aborted;

  // A new write word is taken only when the write slot is free or frees this cycle.
  assign wr_ready = (state == WRITE) && (remaining != '0) && (!av_write || !av_waitrequest);
  assign wr_take  = wr_valid & wr_ready;

  // A read starts only after a low cycle on av_read and with room in the
  // buffer, counting a pop happening in the same cycle.
  assign rd_valid = (fifo_count != '0);
  assign rd_pop   = rd_valid & rd_ready;
  assign rd_push  = av_read & ~av_waitrequest;
  assign rd_start = (state == READ) && !av_read && (remaining != '0) && (!fifo_full || rd_pop);

  av_host_fifo #(
    .depth (c_FIFO_DEPTH),
    .width (c_WORD_SIZE)
  ) u_rd_fifo (
    .clock (clock),
    .reset (reset),
    .flush (timeout_hit),
    .push  (rd_push),
    .pop   (rd_pop),
    .wdata (av_readdata),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection; reads finish only once the buffer has drained.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_take) begin
          if (cmd_len == '0)  state_nxt = FIN;
          else if (cmd_write) state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      WRITE: begin
        if (timeout_hit || (complete && remaining == '0)) state_nxt = FIN;
      end
      READ: begin
        if (timeout_hit || (!av_read && remaining == '0 && fifo_empty)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request, address, word count and wait-timeout bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      av_address   <= '0;
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_writedata <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
      aborted      <= 1'b0;
    end else begin
      if (state == IDLE) aborted <= 1'b0;

      if (cmd_take) begin
        av_address <= cmd_addr;
        remaining  <= cmd_len;
      end else if (complete) begin
        av_address <= av_address + c_ADDR_BITS'(1);
      end

      if (stalled) wait_cnt <= wait_cnt + TW'(1);
      else         wait_cnt <= '0;

      if (wr_take) begin
        av_write     <= 1'b1;
        av_writedata <= wr_data;
        remaining    <= remaining - c_LEN_BITS'(1);
      end else if (complete) begin
        av_write <= 1'b0;
      end

      if (rd_start) begin
        av_read   <= 1'b1;
        remaining <= remaining - c_LEN_BITS'(1);
      end else if (complete) begin
        av_read <= 1'b0;
      end

      if (timeout_hit) begin
        av_read  <= 1'b0;
        av_write <= 1'b0;
        aborted  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_av_esram_host.sv
// Bench for av_esram_host: randomized Avalon slave and stream traffic
// checked against a transfer-level reference model.
module tb_av_esram_host;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_len;
  logic        busy, done, err;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic [15:0] av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest;

  logic        t_cmd_valid, t_cmd_ready, t_cmd_write;
  logic [15:0] t_cmd_addr, t_cmd_len;
  logic        t_busy, t_done, t_err;
  logic [31:0] t_wr_data;
  logic        t_wr_valid, t_wr_ready;
  logic [31:0] t_rd_data;
  logic        t_rd_valid, t_rd_ready;
  logic [15:0] t_av_address;
  logic        t_av_read, t_av_write;
  logic [31:0] t_av_writedata, t_av_readdata;
  logic        t_av_waitrequest;

  always #5 clock = ~clock;

  av_esram_host dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  av_esram_host #(.c_TIMEOUT(8)) dut_to (
    .clock(clock), .reset(reset),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(t_cmd_write),
    .cmd_addr(t_cmd_addr), .cmd_len(t_cmd_len),
    .busy(t_busy), .done(t_done), .err(t_err),
    .wr_data(t_wr_data), .wr_valid(t_wr_valid), .wr_ready(t_wr_ready),
    .rd_data(t_rd_data), .rd_valid(t_rd_valid), .rd_ready(t_rd_ready),
    .av_address(t_av_address), .av_read(t_av_read), .av_write(t_av_write),
    .av_writedata(t_av_writedata), .av_readdata(t_av_readdata),
    .av_waitrequest(t_av_waitrequest)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: memory image, word streams and transfer progress.
  logic [31:0] mem [0:65535];
  logic [31:0] wr_src[$];
  logic [31:0] exp_wq[$];
  logic [31:0] exp_rq[$];
  logic [15:0] exp_addr;
  int  cur_len, n_cmpl, n_pop, n_take, occ, since2, wleft, wait_fix, rd_mode;
  bit  cur_rd, active, xfer_done, exp_done_nxt, exp_rdy_nxt, cmd_pend;
  bit  in_acc, wr_hold, wr_full_rate, prev_stall, prev_rd_cmpl;
  logic [15:0] p_addr;
  logic        p_rd, p_wr;
  logic [31:0] p_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    wr_src.delete(); exp_wq.delete(); exp_rq.delete();
    occ = 0; n_cmpl = 0; n_pop = 0; n_take = 0; since2 = 0; wleft = 0;
    active = 0; xfer_done = 0; exp_done_nxt = 0; exp_rdy_nxt = 0; cmd_pend = 0;
    in_acc = 0; wr_hold = 0; prev_stall = 0; prev_rd_cmpl = 0;
    cmd_valid = 0; wr_valid = 0; rd_ready = 0; av_waitrequest = 0;
  endtask

  // One clock: drive slave and streams at negedge, then sample and check.
  task automatic step();
    @(negedge clock);
    if (av_read || av_write) begin
      if (!in_acc) begin
        in_acc = 1;
        wleft = (wait_fix >= 0) ? wait_fix : $urandom_range(0, 4);
      end
      if (wleft > 0) begin av_waitrequest = 1; wleft--; end
      else begin av_waitrequest = 0; in_acc = 0; end
    end else begin
      av_waitrequest = 0;
      in_acc = 0;
    end
    av_readdata = mem[av_address];
    cmd_valid = cmd_pend;
    if (!wr_hold) begin
      if (wr_src.size() > 0 && (wr_full_rate || $urandom_range(0, 2) != 0)) begin
        wr_valid = 1; wr_data = wr_src[0];
      end else begin
        wr_valid = 0; wr_data = $urandom;
      end
    end
    case (rd_mode)
      0:       rd_ready = 1'($urandom_range(0, 1));
      1:       rd_ready = (n_cmpl >= 2 && since2 >= 10);
      2:       rd_ready = 0;
      default: rd_ready = 1;
    endcase
    #1;
    chk("rw_excl", av_read & av_write, 0);
    if (prev_stall) begin
      chk("hold_addr", av_address, p_addr);
      chk("hold_read", av_read, p_rd);
      chk("hold_write", av_write, p_wr);
      chk("hold_wdata", av_writedata, p_wd);
    end
    if (prev_rd_cmpl) chk("rd_gap", av_read, 0);
    chk("rd_valid", rd_valid, occ != 0);
    if (exp_done_nxt) begin chk("done_time", done, 1); exp_done_nxt = 0; end
    if (exp_rdy_nxt) begin chk("cmd_ready_after", cmd_ready, 1); exp_rdy_nxt = 0; end
    if (active && !done) begin chk("busy", busy, 1); chk("cmd_ready_busy", cmd_ready, 0); end
    if (active && cur_len == 0) chk("len0_bus", av_read | av_write, 0);
    if (done) begin
      chk("done_active", active, 1);
      chk("done_words", n_cmpl, cur_len);
      chk("done_pops", n_pop, cur_rd ? cur_len : 0);
      chk("done_takes", n_take, cur_rd ? 0 : cur_len);
      chk("done_err", err, 0);
      active = 0; xfer_done = 1; exp_rdy_nxt = 1;
    end
    if (av_write && !av_waitrequest) begin
      chk("wr_addr", av_address, exp_addr);
      chk("wr_queued", exp_wq.size() != 0, 1);
      if (exp_wq.size() != 0) chk("wr_data", av_writedata, exp_wq.pop_front());
      mem[av_address] = av_writedata;
      exp_addr++; n_cmpl++;
      if (!cur_rd && n_cmpl == cur_len) exp_done_nxt = 1;
    end
    if (av_read && !av_waitrequest) begin
      chk("rd_addr", av_address, exp_addr);
      exp_rq.push_back(mem[av_address]);
      exp_addr++; n_cmpl++; occ++;
      chk("fifo_occ", occ <= DEPTH, 1);
    end
    if (rd_valid && rd_ready) begin
      chk("rd_queued", exp_rq.size() != 0, 1);
      if (exp_rq.size() != 0) chk("rd_data", rd_data, exp_rq.pop_front());
      occ--; n_pop++;
    end
    if (wr_valid && wr_ready) begin
      exp_wq.push_back(wr_data);
      if (wr_src.size() > 0) wr_src.delete(0);
      n_take++;
    end
    wr_hold = wr_valid && !wr_ready;
    if (cmd_valid && cmd_ready) begin
      cmd_pend = 0; active = 1; exp_addr = cmd_addr;
      cur_len = int'(cmd_len); cur_rd = !cmd_write;
      n_cmpl = 0; n_pop = 0; n_take = 0; since2 = 0;
      if (cmd_len == 0) exp_done_nxt = 1;
    end
    if (n_cmpl >= 2) since2++;
    prev_stall   = (av_read | av_write) & av_waitrequest;
    prev_rd_cmpl = av_read & !av_waitrequest;
    p_addr = av_address; p_rd = av_read; p_wr = av_write; p_wd = av_writedata;
  endtask

  task automatic run_xfer(input bit wr, input logic [15:0] addr, input int len,
                          input int wfix, input int rmode, input bit full_rate,
                          input logic [31:0] dbase);
    wait_fix = wfix; rd_mode = rmode; wr_full_rate = full_rate;
    wr_src.delete();
    if (wr) begin
      for (int i = 0; i < len; i++)
        wr_src.push_back((dbase != 0) ? dbase + 32'(i) : $urandom);
    end
    cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len);
    cmd_pend = 1; xfer_done = 0;
    for (int c = 0; c < 4000 && !xfer_done; c++) step();
    chk("xfer_finished", xfer_done, 1);
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          w, hit;
    logic [15:0] a;
    int          l, stalls;

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    reset = 1;
    cmd_write = 0; cmd_addr = 0; cmd_len = 0; wr_data = 0; av_readdata = 0;
    wait_fix = 0; rd_mode = 3; wr_full_rate = 1; cur_len = 0; cur_rd = 0;
    exp_addr = 0; p_addr = 0; p_rd = 0; p_wr = 0; p_wd = 0;
    clear_model();
    t_cmd_valid = 0; t_cmd_write = 0; t_cmd_addr = 0; t_cmd_len = 0;
    t_wr_data = 0; t_wr_valid = 0; t_rd_ready = 1; t_av_readdata = 0; t_av_waitrequest = 0;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_av_read", av_read, 0);
    chk("rst_av_write", av_write, 0);
    chk("rst_av_address", av_address, 0);
    chk("rst_av_writedata", av_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    reset = 0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Directed transfers.
    run_xfer(1, 16'h0010, 4, 1, 3, 1, 32'h0000_00A0);
    run_xfer(0, 16'h0100, 3, 13, 1, 1, 0);
    run_xfer(1, 16'h2222, 0, 0, 3, 1, 0);
    run_xfer(0, 16'h3333, 0, 0, 3, 1, 0);
    run_xfer(1, 16'hFFFE, 4, 0, 3, 1, 32'h5500_0000);
    run_xfer(0, 16'hFFFE, 4, 2, 3, 1, 0);

    // Randomized transfers.
    for (int k = 0; k < 16; k++) begin
      w = 1'($urandom_range(0, 1));
      a = (k % 4 == 0) ? 16'hFFFB + 16'($urandom_range(0, 4)) : 16'($urandom);
      l = (k == 7) ? 0 : $urandom_range(1, 8);
      run_xfer(w, a, l, -1, 0, 1'($urandom_range(0, 1)), 0);
    end

    // Timeout on the c_TIMEOUT=8 instance with waitrequest stuck high.
    @(negedge clock);
    t_cmd_valid = 1; t_cmd_write = 0; t_cmd_addr = 16'h0400; t_cmd_len = 3;
    t_av_waitrequest = 1;
    #1;
    chk("t_cmd_ready", t_cmd_ready, 1);
    @(negedge clock);
    t_cmd_valid = 0;
    stalls = 0; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      #1;
      if (t_av_read && t_av_waitrequest) stalls++;
      else if (stalls > 0) begin
        hit = 1;
        chk("t_stalls", stalls, 8);
        chk("t_av_read", t_av_read, 0);
        chk("t_done", t_done, 1);
        chk("t_err", t_err, 1);
        chk("t_rd_valid", t_rd_valid, 0);
      end
      @(negedge clock);
    end
    chk("t_abort_seen", hit, 1);
    #1;
    chk("t_cmd_ready_after", t_cmd_ready, 1);
    chk("t_done_after", t_done, 0);
    t_av_waitrequest = 0;

    // Reset during the second read with data waiting in the buffer.
    wait_fix = 6; rd_mode = 2; cmd_write = 0; cmd_addr = 16'h0777; cmd_len = 4;
    cmd_pend = 1; xfer_done = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      step();
      if (n_cmpl == 1 && av_read && rd_valid) hit = 1;
    end
    chk("rst_mid_setup", hit, 1);
    reset = 1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_av_read", av_read, 0);
    chk("mid_rst_av_write", av_write, 0);
    chk("mid_rst_av_address", av_address, 0);
    chk("mid_rst_av_writedata", av_writedata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    clear_model();
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("mid_post_cmd_ready", cmd_ready, 1);
    run_xfer(1, 16'h0800, 3, -1, 0, 1, 0);
    run_xfer(0, 16'h0800, 3, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
